// File: rtl/dma_reg_file_ctl_if.sv
// Command and memory/IO bus channels between the DMA register file controller and its requester/arbiter.
// slave = register file controller side, master = decode stage plus bus arbiter side.
interface dma_reg_file_ctl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_load;
    logic [ADDR_W-1:0] cmd_reg;
    logic              cmd_ready;
    logic              bus_wvalid;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_wready;
    logic              bus_rready;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;
    logic              done;
    logic              timeout;

    modport slave (
        input  cmd_valid, cmd_load, cmd_reg, bus_wready, bus_rvalid, bus_rdata,
        output cmd_ready, bus_wvalid, bus_wdata, bus_rready, done, timeout
    );

    modport master (
        output cmd_valid, cmd_load, cmd_reg, bus_wready, bus_rvalid, bus_rdata,
        input  cmd_ready, bus_wvalid, bus_wdata, bus_rready, done, timeout
    );
endinterface

// File: rtl/dma_reg_file_ctl.sv
// DMA register file: two async read ports, ALU write port, one-register-per-command load/store bus engine.
// Optional REGFILE_BYPASS_EN: reads and store capture see same-cycle write data.
module dma_reg_file_ctl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int INIT_INDEX = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              alu_we,
    input  logic [ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    dma_reg_file_ctl_if.slave bus,
    output logic              collide
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ST_WAIT, LD_WAIT} state_t;

    state_t                        state_q, state_d;
    logic [DEPTH-1:0][DATA_W-1:0]  regs;
    logic [ADDR_W-1:0]             lat_q;
    logic [CNT_W-1:0]              cnt_q;
    logic                          accept, st_hs, ld_hs, expire, alu_hit;
    logic [DATA_W-1:0]             ld_data, cap_data;

    assign ld_data = bus.bus_rdata;
    assign alu_hit = alu_we && (alu_waddr == lat_q);

    function automatic logic [DATA_W-1:0] rd_path(input logic [ADDR_W-1:0] idx);
`ifdef REGFILE_BYPASS_EN
        if (ld_hs && idx == lat_q) return ld_data;
        if (alu_we && idx == alu_waddr) return alu_wdata;
`else
`endif
        return regs[idx];
    endfunction

    assign rd_data_a = rd_path(rd_addr_a);
    assign rd_data_b = rd_path(rd_addr_b);
    assign cap_data  = rd_path(bus.cmd_reg);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        st_hs          = 1'b0;
        ld_hs          = 1'b0;
        expire         = 1'b0;
        bus.cmd_ready  = 1'b0;
        bus.bus_wvalid = 1'b0;
        bus.bus_rready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = bus.cmd_load ? LD_WAIT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                bus.bus_wvalid = 1'b1;
                st_hs          = bus.bus_wready;
            end
            LD_WAIT: begin
                bus.bus_rready = 1'b1;
                ld_hs          = bus.bus_rvalid;
            end
            default: state_d = IDLE;
        endcase
        // A handshake on the last allowed cycle beats the timeout.
        if (state_q == ST_WAIT || state_q == LD_WAIT) begin
            expire = !(st_hs || ld_hs) && (cnt_q == CNT_W'(TIMEOUT - 1));
            if (st_hs || ld_hs || expire) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                regs[k] <= (INIT_INDEX != 0) ? DATA_W'(k) : '0;
            lat_q         <= '0;
            cnt_q         <= '0;
            bus.bus_wdata <= '0;
            bus.done      <= 1'b0;
            bus.timeout   <= 1'b0;
            collide       <= 1'b0;
        end else begin
            bus.done    <= st_hs || ld_hs;
            bus.timeout <= expire;
            collide     <= ld_hs && alu_hit;
            if (accept) begin
                lat_q <= bus.cmd_reg;
                cnt_q <= '0;
                if (!bus.cmd_load) bus.bus_wdata <= cap_data;
            end else if (state_q != IDLE && !st_hs && !ld_hs && !expire) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Bus load owns its register on the handshake edge; a same-index ALU write is dropped.
            if (alu_we && !(ld_hs && alu_hit)) regs[alu_waddr] <= alu_wdata;
            if (ld_hs) regs[lat_q] <= ld_data;
        end
    end
endmodule

// File: tb/tb_dma_reg_file_ctl.sv
// Directed plus randomized bench for dma_reg_file_ctl against an array-based register model.
// Default build only (bypass disabled).
module tb_dma_reg_file_ctl;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rd_addr_a, rd_addr_b, alu_waddr;
    logic [DW-1:0] rd_data_a, rd_data_b, alu_wdata;
    logic          alu_we, collide;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] mdl [16];

    dma_reg_file_ctl_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

    dma_reg_file_ctl #(.DATA_W(DW), .ADDR_W(AW), .INIT_INDEX(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .bus(bif), .collide(collide)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag);
        for (int k = 0; k < 16; k++) begin
            rd_addr_a = AW'(k);
            rd_addr_b = AW'(15 - k);
            #1;
            chk({tag, "_a"}, rd_data_a, mdl[k]);
            chk({tag, "_b"}, rd_data_b, mdl[15 - k]);
        end
    endtask

    // hs: wait cycle (1-based) carrying the bus handshake; anything outside 1..TO never handshakes.
    // alu_mode: 0 none, 1 ALU hits the same register on the handshake cycle, 2 random ALU traffic.
    task automatic do_cmd(input bit ld, input int r, input int hs, input logic [31:0] d, input int alu_mode);
        logic [31:0] exp_wd;
        int nv;
        bit fin, coll;
        chk("cmd_ready_idle", bif.cmd_ready, 1);
        bif.cmd_valid = 1'b1;
        bif.cmd_load  = ld;
        bif.cmd_reg   = AW'(r);
        exp_wd = mdl[r];
        tick();
        bif.cmd_valid = 1'b0;
        nv = 0; fin = 0; coll = 0;
        for (int k = 1; k <= TO; k++) begin
            chk("cmd_ready_wait", bif.cmd_ready, 0);
            chk("rready_wait", bif.bus_rready, ld);
            chk("wvalid_wait", bif.bus_wvalid, !ld);
            if (bif.bus_wvalid) nv++;
            if (!ld) chk("wdata_stable", bif.bus_wdata, exp_wd);
            alu_we = 1'b0;
            if (alu_mode == 2 && $urandom_range(1, 0) == 1) begin
                alu_we    = 1'b1;
                alu_waddr = AW'($urandom_range(15, 0));
                alu_wdata = $urandom;
            end
            if (k == hs) begin
                if (ld) begin
                    bif.bus_rvalid = 1'b1;
                    bif.bus_rdata  = d;
                end else begin
                    bif.bus_wready = 1'b1;
                end
                if (alu_mode == 1) begin
                    alu_we    = 1'b1;
                    alu_waddr = AW'(r);
                    alu_wdata = ~d;
                end
            end
            coll = (k == hs) && ld && alu_we && (int'(alu_waddr) == r);
            if (alu_we && !coll) mdl[alu_waddr] = alu_wdata;
            if (k == hs && ld) mdl[r] = d;
            tick();
            alu_we = 1'b0;
            bif.bus_rvalid = 1'b0;
            bif.bus_wready = 1'b0;
            if (k == hs) begin
                fin = 1;
                break;
            end
        end
        chk("done_pulse", bif.done, fin);
        chk("timeout_pulse", bif.timeout, !fin);
        chk("collide_pulse", collide, coll);
        chk("cmd_ready_end", bif.cmd_ready, 1);
        chk("wvalid_end", bif.bus_wvalid, 0);
        if (!ld) chk("wvalid_cycles", nv, fin ? hs : TO);
        rd_addr_a = AW'(r);
        #1;
        chk("reg_after_cmd", rd_data_a, mdl[r]);
        tick();
        chk("done_one_cycle", bif.done, 0);
        chk("timeout_one_cycle", bif.timeout, 0);
        chk("collide_one_cycle", collide, 0);
    endtask

    initial begin
        rst = 1'b1;
        rd_addr_a = '0; rd_addr_b = '0;
        alu_we = 1'b0; alu_waddr = '0; alu_wdata = '0;
        bif.cmd_valid = 1'b0; bif.cmd_load = 1'b0; bif.cmd_reg = '0;
        bif.bus_wready = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;
        for (int k = 0; k < 16; k++) mdl[k] = k;
        tick();
        tick();
        chk("rst_cmd_ready", bif.cmd_ready, 1);
        chk("rst_wvalid", bif.bus_wvalid, 0);
        chk("rst_rready", bif.bus_rready, 0);
        chk("rst_wdata", bif.bus_wdata, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_timeout", bif.timeout, 0);
        chk("rst_collide", collide, 0);
        rst = 1'b0;

        // Index-valued reset contents
        rd_addr_a = 4'd5; rd_addr_b = 4'd15;
        #1;
        chk("init_a5", rd_data_a, 32'd5);
        chk("init_b15", rd_data_b, 32'd15);
        tick();

        // ALU write visible only after the edge
        alu_we = 1'b1; alu_waddr = 4'd3; alu_wdata = -32'sd7;
        rd_addr_a = 4'd3;
        #1;
        chk("alu_same_cycle", rd_data_a, 32'd3);
        tick();
        alu_we = 1'b0;
        mdl[3] = 32'hFFFF_FFF9;
        #1;
        chk("alu_next_cycle", rd_data_a, 32'hFFFF_FFF9);

        do_cmd(1'b0, 9, 3, 32'h0, 0);                // store, wready on third wait cycle
        do_cmd(1'b1, 4, 1, 32'hA5A5_0001, 1);        // load colliding with ALU write
        chk("collide_reg4", mdl[4], 32'hA5A5_0001);
        do_cmd(1'b1, 2, 0, 32'hDEAD_BEEF, 0);        // load timeout
        chk("timeout_reg2", mdl[2], 32'd2);
        do_cmd(1'b1, 7, TO, 32'h1234_5678, 0);       // handshake on last allowed cycle
        do_cmd(1'b0, 3, TO, 32'h0, 0);               // store at the same boundary
        do_cmd(1'b0, 11, TO + 1, 32'h0, 0);          // store timeout
        sweep("directed");

        // Reset while a store is waiting
        bif.cmd_valid = 1'b1; bif.cmd_load = 1'b0; bif.cmd_reg = 4'd6;
        tick();
        bif.cmd_valid = 1'b0;
        chk("mid_wvalid", bif.bus_wvalid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) mdl[k] = k;
        chk("rst_mid_wvalid", bif.bus_wvalid, 0);
        chk("rst_mid_done", bif.done, 0);
        chk("rst_mid_ready", bif.cmd_ready, 1);
        tick();
        chk("rst_mid_done_later", bif.done, 0);
        chk("rst_mid_timeout_later", bif.timeout, 0);
        sweep("after_reset");

        for (int n = 0; n < 40; n++) begin
            do_cmd(1'($urandom_range(1, 0)), int'($urandom_range(15, 0)),
                   int'($urandom_range(TO + 2, 1)), $urandom, int'($urandom_range(2, 0)));
            if (n % 10 == 9) sweep("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
